// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle control FSM: state encoding, opcode/funct
// constants and the ALUControl, ALUSrcB and PCSrc codes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQ     = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctl_t;

  // ALUOP_NONE is used by states that do not drive the ALU; it yields code 000.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_NONE  = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_RD2    = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } srcb_t;

  typedef enum logic [1:0] {
    PC_ALU_RESULT = 2'b00,
    PC_ALU_OUT    = 2'b01,
    PC_JUMP       = 2'b10
  } pcsrc_t;

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU decoder: maps ALUOp and the R-type Funct field to ALUControl and flags
// unsupported Funct codes while an R-type is executing.
module mc_alu_decoder
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  input  alu_op_t    alu_op,
  output alu_ctl_t   alu_control,
  output logic       illegal
);

  always_comb begin
    alu_control = ALU_AND;
    illegal     = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_control = ALU_ADD;
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: illegal = 1'b1;
        endcase
      end
      default: alu_control = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-subset control FSM with a unified memory handshake.
// Define MC_CTRL_PERF_EN to add the CycleCnt/InstrCnt performance counters.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
)
(
  input  logic             CLK,
  input  logic             reset,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             MemReq,
  output logic             MemWrite,
  output logic             IorD,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUControl,
  output logic [1:0]       PCSrc,
  output logic             PCEn,
  output logic             Illegal,
`ifdef MC_CTRL_PERF_EN
  output logic [CNT_W-1:0] CycleCnt,
  output logic [CNT_W-1:0] InstrCnt,
`endif
  output logic [3:0]       State
);

  state_t   state, state_next;
  alu_op_t  alu_op;
  alu_ctl_t alu_ctl;
  srcb_t    src_b;
  pcsrc_t   pc_src;
  logic     funct_illegal, op_illegal;
  logic     mem_req, mem_write, iord, ir_write, reg_dst, mem_to_reg, reg_write;
  logic     src_a, pc_en;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) state <= S_FETCH;
    // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
    else        state <= state_next;
  end

  // Kept apart from the main decode so the decoder's illegal flag does not feed back.
  always_comb begin
    case (state)
      S_FETCH, S_DECODE, S_MEMADR, S_ADDIEX: alu_op = ALUOP_ADD;
      S_BEQ:                                 alu_op = ALUOP_SUB;
      S_RTYPEEX:                             alu_op = ALUOP_FUNCT;
      default:                               alu_op = ALUOP_NONE;
    endcase
  end

  mc_alu_decoder u_alu_decoder (
    .funct       (Funct),
    .alu_op      (alu_op),
    .alu_control (alu_ctl),
    .illegal     (funct_illegal)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_next = state;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    src_a      = 1'b0;
    src_b      = SRCB_RD2;
    pc_src     = PC_ALU_RESULT;
    pc_en      = 1'b0;
    op_illegal = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        src_b   = SRCB_FOUR;
        if (MemReady) begin
          ir_write   = 1'b1;
          pc_en      = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        src_b = SRCB_IMM_SH;
        case (Op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_RTYPEEX;
          OP_BEQ:       state_next = S_BEQ;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default: begin
            op_illegal = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        src_a      = 1'b1;
        src_b      = SRCB_IMM;
        state_next = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (MemReady) state_next = S_MEMWB;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        if (MemReady) state_next = S_FETCH;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_RTYPEEX: begin
        src_a      = 1'b1;
        state_next = funct_illegal ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_BEQ: begin
        src_a      = 1'b1;
        pc_src     = PC_ALU_OUT;
        pc_en      = Zero;
        state_next = S_FETCH;
      end
      S_ADDIEX: begin
        src_a      = 1'b1;
        src_b      = SRCB_IMM;
        state_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = PC_JUMP;
        pc_en      = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Reset gates every control so the FETCH request is withdrawn while reset is low.
  assign MemReq     = reset & mem_req;
  assign MemWrite   = reset & mem_write;
  assign IorD       = reset & iord;
  assign IRWrite    = reset & ir_write;
  assign RegDst     = reset & reg_dst;
  assign MemtoReg   = reset & mem_to_reg;
  assign RegWrite   = reset & reg_write;
  assign ALUSrcA    = reset & src_a;
  assign ALUSrcB    = reset ? src_b : SRCB_RD2;
  assign ALUControl = reset ? alu_ctl : ALU_AND;
  assign PCSrc      = reset ? pc_src : PC_ALU_RESULT;
  assign PCEn       = reset & pc_en;
  assign Illegal    = reset & (op_illegal | funct_illegal);
  assign State      = state;

`ifdef MC_CTRL_PERF_EN
  logic [CNT_W-1:0] cycle_cnt, instr_cnt;

  // Illegal aborts also return to FETCH but do not retire an instruction.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (state != S_FETCH && state_next == S_FETCH && !Illegal)
        instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end

  assign CycleCnt = cycle_cnt;
  assign InstrCnt = instr_cnt;
`endif

endmodule
